// File: rtl/axi_slave_bridge.sv
// axi_slave_bridge: AXI3 slave that turns single-beat reads/writes into one
// system-bus access each; multi-beat bursts are answered with SLVERR and
// never reach the system bus. One transaction is in flight at a time.
module axi_slave_bridge #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int IW = 4,
   parameter int LW = 4,
   parameter int TO = 32
) (
   input  logic            aclk_i,
   input  logic            arst_i,
   // write address channel
   input  logic [IW-1:0]   awid_i,
   input  logic [LW-1:0]   awlen_i,
   input  logic [2:0]      awsize_i,
   input  logic [1:0]      awburst_i,
   input  logic [AW-1:0]   awaddr_i,
   input  logic [3:0]      awcache_i,
   input  logic [2:0]      awprot_i,
   input  logic [1:0]      awlock_i,
   input  logic            awvalid_i,
   output logic            awready_o,
   // write data channel
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] wstrb_i,
   input  logic            wlast_i,
   input  logic            wvalid_i,
   output logic            wready_o,
   // write response channel
   output logic [IW-1:0]   bid_o,
   output logic [1:0]      bresp_o,
   output logic            bvalid_o,
   input  logic            bready_i,
   // read address channel
   input  logic [IW-1:0]   arid_i,
   input  logic [LW-1:0]   arlen_i,
   input  logic [2:0]      arsize_i,
   input  logic [1:0]      arburst_i,
   input  logic [AW-1:0]   araddr_i,
   input  logic [3:0]      arcache_i,
   input  logic [2:0]      arprot_i,
   input  logic [1:0]      arlock_i,
   input  logic            arvalid_i,
   output logic            arready_o,
   // read data channel
   output logic [IW-1:0]   rid_o,
   output logic [DW-1:0]   rdata_o,
   output logic [1:0]      rresp_o,
   output logic            rlast_o,
   output logic            rvalid_o,
   input  logic            rready_i,
   // system register bus
   output logic [AW-1:0]   sys_addr_o,
   output logic [DW-1:0]   sys_wdata_o,
   output logic [DW/8-1:0] sys_sel_o,
   output logic            sys_wen_o,
   output logic            sys_ren_o,
   input  logic [DW-1:0]   sys_rdata_i,
   input  logic            sys_err_i,
   input  logic            sys_ack_i
);
   localparam int CW = (TO > 1) ? $clog2(TO) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TO - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WDAT, WSYS, WDRN, WRSP, RSYS, RERR, RRSP} state_t;

   state_t         state_reg, state_next;
   logic [IW-1:0]  id_reg;
   logic [LW-1:0]  len_reg;
   logic [LW-1:0]  beat_reg;
   logic [CW-1:0]  tmo_cnt_reg;
   logic           in_idle, in_sys, tmo_hit;
   logic           aw_hs, ar_hs, w_hs;

   // Size/burst type and sideband attributes carry no meaning for a single-access bus.
   logic unused_sideband;
   assign unused_sideband = ^{awsize_i, awburst_i, awcache_i, awprot_i, awlock_i,
                              arsize_i, arburst_i, arcache_i, arprot_i, arlock_i};

   // Ready signals are pure state decodes; write takes priority over read in IDLE.
   assign in_idle   = (state_reg == IDLE) && !arst_i;
   assign awready_o = in_idle;
   assign arready_o = in_idle && !awvalid_i;
   assign wready_o  = !arst_i && ((state_reg == WDAT) || (state_reg == WDRN));
   assign aw_hs     = awvalid_i && awready_o;
   assign ar_hs     = arvalid_i && arready_o;
   assign w_hs      = wvalid_i && wready_o;
   assign in_sys    = (state_reg == WSYS) || (state_reg == RSYS);
   // An ack arriving in the last allowed cycle takes precedence over the timeout.
   assign tmo_hit   = in_sys && !sys_ack_i && (tmo_cnt_reg == TO_LAST);

   // State register.
   always_ff @(posedge aclk_i) begin
      if (arst_i) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (aw_hs)      state_next = (awlen_i == '0) ? WDAT : WDRN;
            else if (ar_hs) state_next = (arlen_i == '0) ? RSYS : RERR;
         end
         WDAT:    if (w_hs)                      state_next = WSYS;
         WSYS:    if (sys_ack_i || tmo_hit)      state_next = WRSP;
         WDRN:    if (w_hs && wlast_i)           state_next = WRSP;
         WRSP:    if (bready_i)                  state_next = IDLE;
         RSYS:    if (sys_ack_i || tmo_hit)      state_next = RRSP;
         RRSP:    if (rready_i)                  state_next = IDLE;
         RERR:    if (rready_i && (beat_reg == len_reg)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ack timeout counter: zero outside a system access, counts waiting cycles inside one.
   always_ff @(posedge aclk_i) begin
      if (arst_i || !in_sys || sys_ack_i) tmo_cnt_reg <= '0;
      else                                tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
   end

   // Request latching, system-bus strobes and AXI response registers.
   always_ff @(posedge aclk_i) begin
      if (arst_i) begin
         id_reg      <= '0;
         len_reg     <= '0;
         beat_reg    <= '0;
         sys_addr_o  <= '0;
         sys_wdata_o <= '0;
         sys_sel_o   <= '0;
         sys_wen_o   <= 1'b0;
         sys_ren_o   <= 1'b0;
         bid_o       <= '0;
         bresp_o     <= RESP_OKAY;
         bvalid_o    <= 1'b0;
         rid_o       <= '0;
         rdata_o     <= '0;
         rresp_o     <= RESP_OKAY;
         rlast_o     <= 1'b0;
         rvalid_o    <= 1'b0;
      end else begin
         sys_wen_o <= 1'b0;
         sys_ren_o <= 1'b0;

         if (aw_hs) begin
            id_reg     <= awid_i;
            len_reg    <= awlen_i;
            sys_addr_o <= awaddr_i;
         end else if (ar_hs) begin
            id_reg     <= arid_i;
            len_reg    <= arlen_i;
            sys_addr_o <= araddr_i;
            beat_reg   <= '0;
            if (arlen_i == '0) begin
               sys_ren_o <= 1'b1;
            end else begin
               // Burst read: start streaming error beats straight away.
               rid_o    <= arid_i;
               rdata_o  <= '0;
               rresp_o  <= RESP_SLVERR;
               rlast_o  <= 1'b0;
               rvalid_o <= 1'b1;
            end
         end

         if ((state_reg == WDAT) && w_hs) begin
            sys_wdata_o <= wdata_i;
            sys_sel_o   <= wstrb_i;
            sys_wen_o   <= 1'b1;
         end

         if ((state_reg == WSYS) && (sys_ack_i || tmo_hit)) begin
            bid_o    <= id_reg;
            bresp_o  <= (sys_ack_i && !sys_err_i) ? RESP_OKAY : RESP_SLVERR;
            bvalid_o <= 1'b1;
         end else if ((state_reg == WDRN) && w_hs && wlast_i) begin
            bid_o    <= id_reg;
            bresp_o  <= RESP_SLVERR;
            bvalid_o <= 1'b1;
         end else if ((state_reg == WRSP) && bready_i) begin
            bvalid_o <= 1'b0;
         end

         if ((state_reg == RSYS) && (sys_ack_i || tmo_hit)) begin
            rid_o    <= id_reg;
            rdata_o  <= sys_ack_i ? sys_rdata_i : '0;
            rresp_o  <= (sys_ack_i && !sys_err_i) ? RESP_OKAY : RESP_SLVERR;
            rlast_o  <= 1'b1;
            rvalid_o <= 1'b1;
         end else if ((state_reg == RRSP) && rready_i) begin
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
         end else if ((state_reg == RERR) && rready_i) begin
            if (beat_reg == len_reg) begin
               rvalid_o <= 1'b0;
               rlast_o  <= 1'b0;
            end else begin
               beat_reg <= beat_reg + LW'(1);
               rlast_o  <= ((beat_reg + LW'(1)) == len_reg);
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_slave_bridge.sv
// tb_axi_slave_bridge: directed vectors for single accesses plus hand-written
// sequences for timeout, write/read collision, bursts and reset mid-access.
module tb_axi_slave_bridge;
   localparam int TO = 32;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        aclk_i = 1'b0;
   logic        arst_i;
   logic [3:0]  awid_i, arid_i, awlen_i, arlen_i;
   logic [2:0]  awsize_i, arsize_i, awprot_i, arprot_i;
   logic [1:0]  awburst_i, arburst_i, awlock_i, arlock_i;
   logic [3:0]  awcache_i, arcache_i;
   logic [31:0] awaddr_i, araddr_i, wdata_i, sys_rdata_i;
   logic [3:0]  wstrb_i;
   logic        awvalid_i, wlast_i, wvalid_i, bready_i, arvalid_i, rready_i;
   logic        sys_err_i, sys_ack_i;
   logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
   logic [3:0]  bid_o, rid_o;
   logic [1:0]  bresp_o, rresp_o;
   logic [31:0] rdata_o, sys_addr_o, sys_wdata_o;
   logic [3:0]  sys_sel_o;
   logic        sys_wen_o, sys_ren_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit          wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [31:0] data;   // write data, or read data returned by the system bus
      logic [3:0]  strb;
      int          dly;    // cycles from strobe to ack
      bit          err;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [7];

   always #5 aclk_i = ~aclk_i;

   axi_slave_bridge #(.AW(32), .DW(32), .IW(4), .LW(4), .TO(TO)) dut (
      .aclk_i(aclk_i), .arst_i(arst_i),
      .awid_i(awid_i), .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
      .awaddr_i(awaddr_i), .awcache_i(awcache_i), .awprot_i(awprot_i), .awlock_i(awlock_i),
      .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
      .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
      .araddr_i(araddr_i), .arcache_i(arcache_i), .arprot_i(arprot_i), .arlock_i(arlock_i),
      .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i),
      .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
      .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
      .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Single-beat write; dly < 0 means the system bus never acknowledges.
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int dly, input logic err,
                           input logic [1:0] exp_resp);
      int lat;
      awvalid_i = 1'b1; awid_i = id; awaddr_i = addr; awlen_i = 4'd0;
      wvalid_i = 1'b1; wdata_i = data; wstrb_i = strb; wlast_i = 1'b1;
      check("wr_awready", 32'(awready_o), 32'd1);
      @(negedge aclk_i);
      awvalid_i = 1'b0;
      check("wr_wready", 32'(wready_o), 32'd1);
      @(negedge aclk_i);
      wvalid_i = 1'b0; wlast_i = 1'b0;
      check("wr_wen", 32'(sys_wen_o), 32'd1);
      check("wr_addr", sys_addr_o, addr);
      check("wr_wdata", sys_wdata_o, data);
      check("wr_sel", 32'(sys_sel_o), 32'(strb));
      lat = -1;
      for (int i = 0; i <= TO + 4; i++) begin
         if (i == 1) check("wr_wen_pulse", 32'(sys_wen_o), 32'd0);
         if (bvalid_o) begin lat = i; break; end
         sys_ack_i = (i == dly); sys_err_i = err;
         @(negedge aclk_i);
      end
      sys_ack_i = 1'b0; sys_err_i = 1'b0;
      check("wr_latency", 32'(lat), 32'((dly < 0) ? TO : dly + 1));
      check("wr_bid", 32'(bid_o), 32'(id));
      check("wr_bresp", 32'(bresp_o), 32'(exp_resp));
      @(negedge aclk_i);
      check("wr_bhold", 32'(bvalid_o), 32'd1);
      bready_i = 1'b1;
      @(negedge aclk_i);
      bready_i = 1'b0;
      check("wr_bdone", 32'(bvalid_o), 32'd0);
      $display("write id=%h addr=%h data=%h strb=%h dly=%0d -> bresp=%b lat=%0d",
               id, addr, data, strb, dly, bresp_o, lat);
   endtask

   // Single-beat read; dly < 0 means the system bus never acknowledges.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] bus_data,
                          input int dly, input logic err, input logic [1:0] exp_resp,
                          input logic [31:0] exp_rdata);
      int lat;
      arvalid_i = 1'b1; arid_i = id; araddr_i = addr; arlen_i = 4'd0;
      check("rd_arready", 32'(arready_o), 32'd1);
      @(negedge aclk_i);
      arvalid_i = 1'b0;
      check("rd_ren", 32'(sys_ren_o), 32'd1);
      check("rd_addr", sys_addr_o, addr);
      lat = -1;
      for (int i = 0; i <= TO + 4; i++) begin
         if (i == 1) check("rd_ren_pulse", 32'(sys_ren_o), 32'd0);
         if (rvalid_o) begin lat = i; break; end
         sys_ack_i = (i == dly); sys_err_i = err; sys_rdata_i = bus_data;
         @(negedge aclk_i);
      end
      sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = 32'h0;
      check("rd_latency", 32'(lat), 32'((dly < 0) ? TO : dly + 1));
      check("rd_rid", 32'(rid_o), 32'(id));
      check("rd_rresp", 32'(rresp_o), 32'(exp_resp));
      check("rd_rdata", rdata_o, exp_rdata);
      check("rd_rlast", 32'(rlast_o), 32'd1);
      @(negedge aclk_i);
      check("rd_rhold", 32'(rvalid_o), 32'd1);
      rready_i = 1'b1;
      @(negedge aclk_i);
      rready_i = 1'b0;
      check("rd_rdone", 32'(rvalid_o), 32'd0);
      $display("read  id=%h addr=%h dly=%0d -> rresp=%b rdata=%h lat=%0d",
               id, addr, dly, rresp_o, rdata_o, lat);
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'h3, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF,  2, 1'b0, OKAY};
      vecs[1] = '{1'b0, 4'h5, 32'h4000_0020, 32'h1234_5678, 4'h0,  1, 1'b0, OKAY};
      vecs[2] = '{1'b1, 4'hA, 32'h4000_1004, 32'h0000_A5A5, 4'h3,  0, 1'b1, SLVERR};
      vecs[3] = '{1'b0, 4'hF, 32'h4000_FFFC, 32'hCAFE_F00D, 4'h0,  0, 1'b1, SLVERR};
      vecs[4] = '{1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 4'h8,  5, 1'b0, OKAY};
      vecs[5] = '{1'b0, 4'h1, 32'h7FFF_FFFC, 32'h0BAD_C0DE, 4'h0, 31, 1'b0, OKAY};
      vecs[6] = '{1'b1, 4'h2, 32'h4000_0008, 32'h8000_0001, 4'h1, 31, 1'b0, OKAY};

      arst_i = 1'b1;
      awid_i = '0; arid_i = '0; awlen_i = '0; arlen_i = '0;
      awsize_i = 3'd2; arsize_i = 3'd2; awburst_i = 2'd1; arburst_i = 2'd1;
      awprot_i = '0; arprot_i = '0; awlock_i = '0; arlock_i = '0;
      awcache_i = '0; arcache_i = '0;
      awaddr_i = '0; araddr_i = '0; wdata_i = '0; wstrb_i = '0; sys_rdata_i = '0;
      awvalid_i = 1'b0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
      arvalid_i = 1'b0; rready_i = 1'b0; sys_err_i = 1'b0; sys_ack_i = 1'b0;

      // Reset state
      repeat (3) @(negedge aclk_i);
      check("rst_awready", 32'(awready_o), 32'd0);
      check("rst_arready", 32'(arready_o), 32'd0);
      check("rst_wready", 32'(wready_o), 32'd0);
      check("rst_bvalid", 32'(bvalid_o), 32'd0);
      check("rst_rvalid", 32'(rvalid_o), 32'd0);
      check("rst_rlast", 32'(rlast_o), 32'd0);
      check("rst_wen", 32'(sys_wen_o), 32'd0);
      check("rst_ren", 32'(sys_ren_o), 32'd0);
      check("rst_sys_addr", sys_addr_o, 32'h0);
      check("rst_sys_wdata", sys_wdata_o, 32'h0);
      check("rst_sys_sel", 32'(sys_sel_o), 32'h0);
      check("rst_ids", 32'({bid_o, rid_o}), 32'h0);
      check("rst_resps", 32'({bresp_o, rresp_o}), 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      arst_i = 1'b0;
      @(negedge aclk_i);
      check("idle_awready", 32'(awready_o), 32'd1);
      check("idle_arready", 32'(arready_o), 32'd1);
      awvalid_i = 1'b1;
      #1;
      check("idle_arready_masked", 32'(arready_o), 32'd0);
      awvalid_i = 1'b0;

      // Directed single-beat table
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].wr)
            do_write(vecs[v].id, vecs[v].addr, vecs[v].data, vecs[v].strb,
                     vecs[v].dly, vecs[v].err, vecs[v].resp);
         else
            do_read(vecs[v].id, vecs[v].addr, vecs[v].data, vecs[v].dly,
                    vecs[v].err, vecs[v].resp, vecs[v].data);
      end

      // Timeouts: no ack at all
      do_read(4'h2, 32'h4000_0030, 32'hFFFF_FFFF, -1, 1'b0, SLVERR, 32'h0);
      do_write(4'h4, 32'h4000_0034, 32'h0000_0042, 4'hF, -1, 1'b0, SLVERR);

      // AW+W and AR together: write first, read after B
      arvalid_i = 1'b1; arid_i = 4'h7; araddr_i = 32'h4000_0044; arlen_i = 4'd0;
      awvalid_i = 1'b1; awlen_i = 4'd0;
      #1;
      check("sim_arready_blocked", 32'(arready_o), 32'd0);
      do_write(4'h8, 32'h4000_0040, 32'h0000_1111, 4'hF, 1, 1'b0, OKAY);
      do_read(4'h7, 32'h4000_0044, 32'h2222_0000, 0, 1'b0, OKAY, 32'h2222_0000);

      // Burst write: 4 beats drained, no system strobe, single SLVERR
      awvalid_i = 1'b1; awid_i = 4'h6; awaddr_i = 32'h4000_0100; awlen_i = 4'd3;
      wvalid_i = 1'b1; wlast_i = 1'b0; wstrb_i = 4'hF;
      check("bw_awready", 32'(awready_o), 32'd1);
      @(negedge aclk_i);
      awvalid_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
         wlast_i = (b == 3); wdata_i = 32'(b);
         check("bw_wready", 32'(wready_o), 32'd1);
         @(negedge aclk_i);
         check("bw_no_wen", 32'(sys_wen_o), 32'd0);
         if (b < 3) check("bw_early_b", 32'(bvalid_o), 32'd0);
      end
      wvalid_i = 1'b0; wlast_i = 1'b0;
      check("bw_bvalid", 32'(bvalid_o), 32'd1);
      check("bw_bresp", 32'(bresp_o), 32'(SLVERR));
      check("bw_bid", 32'(bid_o), 32'h6);
      bready_i = 1'b1;
      @(negedge aclk_i);
      bready_i = 1'b0;
      check("bw_bdone", 32'(bvalid_o), 32'd0);
      $display("burst write id=6 len=3 -> bresp=%b", bresp_o);

      // Burst read: 3 error beats, rlast on the last, rready toggled
      arvalid_i = 1'b1; arid_i = 4'h9; araddr_i = 32'h4000_0200; arlen_i = 4'd2;
      check("br_arready", 32'(arready_o), 32'd1);
      @(negedge aclk_i);
      arvalid_i = 1'b0;
      check("br_no_ren", 32'(sys_ren_o), 32'd0);
      for (int b = 0; b < 3; b++) begin
         check("br_rvalid", 32'(rvalid_o), 32'd1);
         check("br_rlast", 32'(rlast_o), 32'(b == 2));
         check("br_rresp", 32'(rresp_o), 32'(SLVERR));
         check("br_rdata", rdata_o, 32'h0);
         check("br_rid", 32'(rid_o), 32'h9);
         @(negedge aclk_i);
         check("br_hold", 32'({rvalid_o, rlast_o}), 32'({1'b1, b == 2}));
         rready_i = 1'b1;
         @(negedge aclk_i);
         rready_i = 1'b0;
         $display("burst read beat %0d rlast=%b", b, b == 2);
      end
      check("br_done", 32'(rvalid_o), 32'd0);

      // Reset while waiting in WSYS: the write is dropped with no B
      awvalid_i = 1'b1; awid_i = 4'h2; awaddr_i = 32'h4000_0300; awlen_i = 4'd0;
      wvalid_i = 1'b1; wdata_i = 32'h5555_AAAA; wstrb_i = 4'hF; wlast_i = 1'b1;
      @(negedge aclk_i);
      awvalid_i = 1'b0;
      @(negedge aclk_i);
      wvalid_i = 1'b0; wlast_i = 1'b0;
      check("rm_wen", 32'(sys_wen_o), 32'd1);
      arst_i = 1'b1;
      @(negedge aclk_i);
      check("rm_wready", 32'(wready_o), 32'd0);
      check("rm_bvalid", 32'(bvalid_o), 32'd0);
      check("rm_wen_off", 32'(sys_wen_o), 32'd0);
      check("rm_sys_addr", sys_addr_o, 32'h0);
      arst_i = 1'b0;
      sys_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk_i);
         sys_ack_i = 1'b0;
         check("rm_no_b", 32'(bvalid_o), 32'd0);
      end
      $display("reset mid-access: write dropped");
      do_write(4'hC, 32'h4000_0304, 32'h0F0F_0F0F, 4'h5, 1, 1'b0, OKAY);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_slave_bridge.md
# axi_slave_bridge

AXI3 slave that terminates transactions from the PS/interconnect (or from the AXI master bench model) and converts them into the single-access system register bus used by the FPGA modules. Serves one transaction at a time: single-beat reads and writes go to the system bus, wait for the acknowledge and come back as OKAY/SLVERR responses. Multi-beat bursts get an error response and never touch the bus. Sits directly downstream of the AXI master and upstream of the system-bus address decoder.

## Interface
- AW, default 32: address width.
- DW, default 32: data width; only 32 is supported.
- IW, default 4: ID width.
- LW, default 4: burst length width.
- TO, default 32: system-bus ack timeout, in cycles.

- aclk_i  in  1  the only clock.
- arst_i  in  1  reset, synchronous and active-high.
- awid_i/awlen_i/awsize_i/awburst_i/awaddr_i  in  IW/LW/3/2/AW  write address fields; awsize_i and awburst_i are ignored.
- awcache_i/awprot_i/awlock_i/arcache_i/arprot_i/arlock_i  in  4/3/2  sideband, ignored.
- awvalid_i in 1, awready_o out 1: write address handshake.
- wdata_i in DW, wstrb_i in DW/8, wlast_i in 1, wvalid_i in 1, wready_o out 1: write data channel.
- bid_o out IW, bresp_o out 2, bvalid_o out 1, bready_i in 1: write response channel.
- arid_i/arlen_i/arsize_i/arburst_i/araddr_i  in  IW/LW/3/2/AW  read address fields; arsize_i and arburst_i are ignored.
- arvalid_i in 1, arready_o out 1: read address handshake.
- rid_o out IW, rdata_o out DW, rresp_o out 2, rlast_o out 1, rvalid_o out 1, rready_i in 1: read data channel.
- sys_addr_o out AW, sys_wdata_o out DW, sys_sel_o out DW/8: system-bus address, write data and byte enables.
- sys_wen_o out 1, sys_ren_o out 1: one-cycle write and read strobes.
- sys_rdata_i in DW, sys_err_i in 1, sys_ack_i in 1: read data, error flag and access acknowledge.

## Operation
- FSM states: IDLE, WDAT, WSYS, WDRN, WRSP, RSYS, RERR, RRSP.
- IDLE: awready_o=1 and arready_o=!awvalid_i. Write wins when both are valid in the same cycle.
- AW handshake: latch id, addr and len.
  - len==0 → WDAT.
  - len!=0 → WDRN.
- WDAT: wready_o=1. On the W handshake, latch wdata and wstrb into sys_wdata_o and sys_sel_o, then go to WSYS. wlast_i is not checked.
- WSYS: sys_wen_o is high for the first cycle only. The state ends on ack or timeout, then goes to WRSP.
  - ack → bresp = sys_err_i ? 2'b10 : 2'b00.
  - timeout → bresp = 2'b10.
- WDRN: wready_o=1. Discard beats until a handshake with wlast_i=1, then go to WRSP with bresp 2'b10. No sys strobe is issued.
- WRSP: bvalid_o=1 with bid_o equal to the latched id. Hold until bready_i, then go to IDLE.
- AR handshake: latch id, addr and len.
  - len==0 → RSYS.
  - len!=0 → RERR.
- RSYS: sys_ren_o is high for the first cycle only.
  - ack → capture sys_rdata_i; rresp = sys_err_i ? 2'b10 : 2'b00.
  - timeout → rdata 0, rresp 2'b10.
  - Either way, go to RRSP.
- RRSP: rvalid_o=1 and rlast_o=1. Hold until rready_i, then go to IDLE.
- RERR: emit len+1 beats with rdata 0 and rresp 2'b10. rlast_o=1 on the final beat only. Each beat is held until rready_i. Return to IDLE after the last handshake.
- Timeout counter: cleared when entering WSYS/RSYS and incremented each cycle without ack. Timeout fires in the cycle where the count reaches TO-1 with no ack. An ack in that same cycle wins.
- sys_ack_i is ignored outside WSYS/RSYS.
- sys_addr_o holds the latched address from the AW/AR handshake until the next handshake.
- sys_wdata_o and sys_sel_o hold their value until the next W handshake in WDAT.

## Timing
- Reset (arst_i=1 at a clock edge) forces the state to IDLE and clears the timeout counter. It applies from any state, including mid-burst and mid-sys access; the pending transaction is dropped with no response.
- Register outputs after reset: sys_* address/data/sel all 0; bid_o, rid_o, bresp_o, rresp_o, rdata_o all 0.
- Handshake outputs during reset: bvalid_o, rvalid_o, rlast_o, wready_o, sys_wen_o and sys_ren_o are 0, and awready_o and arready_o are 0 while arst_i=1. Once arst_i is low with the FSM in IDLE, awready_o=1 and arready_o=!awvalid_i.
- awready_o, arready_o and wready_o are combinational decodes of the state. All other outputs are registered.
- Write, AW and W valid from cycle N:
  - AW handshake at N; W handshake at N+1.
  - sys_wen_o at N+2.
  - Ack at the earliest in N+2 → bvalid_o at N+3.
- Read: AR handshake at N → sys_ren_o at N+1; ack at K≥N+1 → rvalid_o at K+1.
- Timeout with no ack and the strobe at cycle S: response valid at S+TO.
- B and R valid stay stable until their handshake. The next address handshake is possible in the cycle after the response handshake.

## Test plan
- Single write:
  - Stimulus: addr 0x40000010, data 0xDEADBEEF, strb 0xF, id 3; ack with err=0 two cycles after the wen pulse.
  - Required: one wen pulse carrying those addr/data/sel; then bid 3, bresp 0.
- Single read:
  - Stimulus: addr 0x40000020, id 5; ack one cycle after ren with rdata 0x12345678.
  - Required: rvalid with rdata 0x12345678, rid 5, rresp 0, rlast 1.
- Timeout, TO=32:
  - Stimulus: read with no ack.
  - Required: rvalid exactly 32 cycles after ren, rresp 2'b10, rdata 0.
- Simultaneous AW+W and AR in the same cycle:
  - Required: write is served first and the read follows after B; both respond OKAY.
- Bursts:
  - Stimulus: write with awlen 3 (4 beats, wlast on the 4th); read with arlen 2.
  - Required (write): no wen; one B with bresp 2'b10.
  - Required (read): 3 R beats with SLVERR, rlast on the 3rd only; rready is toggled between beats.
- Reset mid-access:
  - Stimulus: assert arst_i while in WSYS.
  - Required: next cycle wready_o, bvalid_o and sys_wen_o are all 0, and no B is issued; after arst_i is released, a new write completes normally.
